i2c_scl_scheduler: RTL and testbench
====================================

# i2c_scl_scheduler

Sequences I2C SCL timing from the system clock by dividing it into four equal quarter-phases per SCL period and reporting each phase entry to the bit-level I2C engine. It drives the open-drain SCL request and honours slave clock stretching during the high half. It replaces free-running clock division on the bus path with a start/stop-controllable, stretch-aware scheduler. The I2C master FSM uses its phase strobes to change SDA (phase 0) and to sample SDA (phase 2).

## Interface
- INPUT_CLOCK_SPEED, 50000000, system clock frequency in Hz.
- SCL_SPEED, 100000, target SCL frequency in Hz.
- STRETCH_TIMEOUT, 0, maximum system cycles SCL may be held low by a slave in phase 2; 0 disables the timeout.
- inputClock  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  request to run SCL; it is sampled only in IDLE and at the end of phase 3.
- sclIn  input  1  SCL bus level, already synchronized upstream.
- sclOut  output  1  SCL drive request: 0 = pull low, 1 = release.
- phase  output  2  current quarter-phase: 0/1 = SCL low, 2/3 = SCL high.
- phaseStrobe  output  1  one-cycle pulse in the first cycle of every phase.
- busy  output  1  high whenever the state is not IDLE.
- stretched  output  1  high while the counter is frozen by a slave stretch.
- timeoutErr  output  1  one-cycle pulse when a stretch exceeds STRETCH_TIMEOUT.

## Operation
- Divider widths:
  - QUARTER = INPUT_CLOCK_SPEED / (SCL_SPEED*4), using integer truncation.
  - If QUARTER < 2, elaboration fails.
  - The counter width is $clog2(QUARTER).
  - The stretch counter width is $clog2(STRETCH_TIMEOUT+1).
- States: IDLE, RUN, STRETCH.
- IDLE:
  - Outputs: sclOut=1, phase=3, busy=0.
  - Both counters are held at 0.
  - enable=1 moves the state to RUN and enters phase 0.
- RUN:
  - The counter runs 0..QUARTER-1.
  - At QUARTER-1 the counter returns to 0 and the next phase is entered.
  - Entering phase 0 drives sclOut=0.
  - Entering phase 2 drives sclOut=1.
- Stretch check:
  - Applies only in phase 2, in any cycle where sclIn=0.
  - The state moves to STRETCH, the counter freezes and stretched=1.
  - sclIn low in phases 0, 1 or 3 is ignored.
- STRETCH:
  - sclOut stays 1 and the stretch counter increments each cycle.
  - sclIn=1 returns the state to RUN. The counter resumes from its frozen value, stretched=0 and the stretch counter clears.
  - If STRETCH_TIMEOUT≠0 and the stretch counter reaches STRETCH_TIMEOUT-1 while sclIn=0:
    - timeoutErr pulses and the state goes to IDLE.
    - sclOut=1 and no strobe is issued.
- End of phase 3:
  - enable=1 wraps to phase 0 with a strobe.
  - enable=0 goes to IDLE with no strobe.
  - An in-progress SCL period always completes; enable falling mid-period has no effect until the end of phase 3.
- Reset (at any time, including mid-stretch):
  - Forces IDLE immediately.
  - sclOut=1, phase=3, phaseStrobe=0, busy=0, stretched=0, timeoutErr=0, both counters 0.

## Timing
- enable sampled high in IDLE at edge T: at T+1, phase=0, sclOut=0, phaseStrobe=1, busy=1.
- Without stretching:
  - Each phase lasts exactly QUARTER cycles.
  - The SCL period is 4*QUARTER cycles.
  - Strobes are spaced QUARTER cycles apart.
- sclOut changes in the same cycle as the phaseStrobe for phase 0 and phase 2.
- Synchronizer lag on sclIn is absorbed naturally: phase 2 freezes until sclIn reads 1, so phase 2 lasts QUARTER cycles plus the lag.
- A stretch of N cycles extends phase 2 by exactly N cycles. Phase 3 is unaffected.
- timeoutErr asserts STRETCH_TIMEOUT cycles after STRETCH entry; busy falls in the same cycle.
- Back-to-back periods have no idle cycle between the phase 3 end and the next phase 0 strobe.

## Test plan
- Basic run: INPUT_CLOCK_SPEED=4000000, SCL_SPEED=100000 (QUARTER=10); enable held 1 with sclIn=sclOut. Required: phase sequence 0,1,2,3,0… with strobes every 10 cycles; sclOut low for 20 cycles then high for 20; busy=1.
- Stop: drop enable mid-phase 1. Required: phases 1, 2 and 3 complete; the state returns to IDLE with sclOut=1, busy=0, phase=3, and no further strobe.
- Stretch: hold sclIn=0 for 37 cycles after the phase 2 strobe. Required: stretched=1 for those cycles; phase 2 lasts 47 cycles; phase 3 lasts 10.
- Timeout: STRETCH_TIMEOUT=50, hold sclIn=0 indefinitely. Required: timeoutErr pulses exactly once, 50 cycles after STRETCH entry; IDLE with sclOut=1.
- Reset: assert reset_n=0 mid-STRETCH, asynchronously off a clock edge. Required: all outputs reach their reset values before the next edge; after release with enable=1, phase 0 is strobed one cycle after the first edge.
- Glitch immunity: pulse sclIn=0 during phase 0 and phase 3. Required: no stretch and no timing change.

Source files
------------

// File: rtl/i2c_scl_scheduler.sv
// SCL quarter-phase scheduler: divides clk into four equal phases per SCL period,
// drives the open-drain SCL request and freezes phase 2 while a slave stretches the clock.
module i2c_scl_scheduler #(
    parameter int INPUT_CLOCK_SPEED = 50000000,
    parameter int SCL_SPEED         = 100000,
    parameter int STRETCH_TIMEOUT   = 0
) (
    input  logic       inputClock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sclIn,
    output logic       sclOut,
    output logic [1:0] phase,
    output logic       phaseStrobe,
    output logic       busy,
    output logic       stretched,
    output logic       timeoutErr
);
    localparam int QUARTER = INPUT_CLOCK_SPEED / (SCL_SPEED * 4);
    localparam int CW      = (QUARTER < 2) ? 1 : $clog2(QUARTER);
    localparam int SW      = (STRETCH_TIMEOUT < 1) ? 1 : $clog2(STRETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] Q_LAST = CW'(QUARTER - 1);
    localparam logic [SW-1:0] T_LAST = SW'((STRETCH_TIMEOUT > 0) ? STRETCH_TIMEOUT - 1 : 0);

    if (QUARTER < 2) begin : g_quarter_check
        $error("i2c_scl_scheduler: QUARTER must be at least 2");
    end

    // state   | meaning
    // IDLE    | SCL released, waiting for enable
    // RUN     | counting quarter-phases
    // STRETCH | phase 2 frozen while a slave holds SCL low
    typedef enum logic [1:0] {IDLE, RUN, STRETCH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;

    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            scnt        <= '0;
            sclOut      <= 1'b1;
            phase       <= 2'd3;
            phaseStrobe <= 1'b0;
            busy        <= 1'b0;
            stretched   <= 1'b0;
            timeoutErr  <= 1'b0;
        end else begin
            phaseStrobe <= 1'b0;
            timeoutErr  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    scnt <= '0;
                    if (enable) begin
                        state       <= RUN;
                        phase       <= 2'd0;
                        sclOut      <= 1'b0;
                        phaseStrobe <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN, STRETCH: begin
                    // A low bus in phase 2 does not count toward the quarter.
                    if (phase == 2'd2 && !sclIn) begin
                        if (STRETCH_TIMEOUT != 0 && state == STRETCH && scnt == T_LAST) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            scnt       <= '0;
                            sclOut     <= 1'b1;
                            phase      <= 2'd3;
                            busy       <= 1'b0;
                            stretched  <= 1'b0;
                            timeoutErr <= 1'b1;
                        end else begin
                            state     <= STRETCH;
                            stretched <= 1'b1;
                            if (state == STRETCH) begin
                                scnt <= scnt + 1'b1;
                            end
                        end
                    end else begin
                        state     <= RUN;
                        stretched <= 1'b0;
                        scnt      <= '0;
                        if (cnt == Q_LAST) begin
                            cnt <= '0;
                            case (phase)
                                2'd0: begin
                                    phase       <= 2'd1;
                                    phaseStrobe <= 1'b1;
                                end
                                2'd1: begin
                                    phase       <= 2'd2;
                                    sclOut      <= 1'b1;
                                    phaseStrobe <= 1'b1;
                                end
                                2'd2: begin
                                    phase       <= 2'd3;
                                    phaseStrobe <= 1'b1;
                                end
                                default: begin
                                    if (enable) begin
                                        phase       <= 2'd0;
                                        sclOut      <= 1'b0;
                                        phaseStrobe <= 1'b1;
                                    end else begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end
                                end
                            endcase
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_scl_scheduler.sv
// Bench for i2c_scl_scheduler: expected per-cycle trace built from period-level timing
// arithmetic, plus hand sequences for timeout and asynchronous reset mid-stretch.
module tb_i2c_scl_scheduler;
    localparam int Q   = 10;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       scl_in = 1'b1;
    logic       scl_out;
    logic [1:0] phase;
    logic       strobe;
    logic       busy;
    logic       stretched;
    logic       tmo_err;

    int checks = 0;
    int errors = 0;

    i2c_scl_scheduler #(
        .INPUT_CLOCK_SPEED(4000000),
        .SCL_SPEED        (100000),
        .STRETCH_TIMEOUT  (TMO)
    ) dut (
        .inputClock (clk),
        .reset_n    (rst_n),
        .enable     (enable),
        .sclIn      (scl_in),
        .sclOut     (scl_out),
        .phase      (phase),
        .phaseStrobe(strobe),
        .busy       (busy),
        .stretched  (stretched),
        .timeoutErr (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       si;
        bit [1:0] ph;
        bit       stb;
        bit       so;
        bit       bsy;
        bit       str;
    } vec_t;

    typedef struct {
        int idle_len;
        int n;
        bit cont;
    } period_t;

    vec_t tr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {phase, strobe, scl_out, busy, stretched, tmo_err};
    endfunction

    task automatic add_idle(input int len, input bit start);
        for (int i = 0; i < len; i++) begin
            vec_t v;
            v.en  = start && (i == len - 1);
            v.si  = 1'($urandom_range(0, 1));
            v.ph  = 2'd3;
            v.stb = 1'b0;
            v.so  = 1'b1;
            v.bsy = 1'b0;
            v.str = 1'b0;
            tr.push_back(v);
        end
    endtask

    // One SCL period: phases of Q cycles, phase 2 stretched by n cycles of sclIn low.
    task automatic add_period(input int n, input bit cont);
        for (int p = 0; p < 4; p++) begin
            int len;
            len = Q + ((p == 2) ? n : 0);
            for (int i = 0; i < len; i++) begin
                vec_t v;
                v.ph  = 2'(p);
                v.stb = (i == 0);
                v.so  = (p >= 2);
                v.bsy = 1'b1;
                v.str = (p == 2) && (i >= 1) && (i <= n);
                if (p == 2) v.si = (i >= n);
                else        v.si = ($urandom_range(0, 3) != 0);
                if (p == 3 && i == len - 1) v.en = cont;
                else                        v.en = 1'($urandom_range(0, 1));
                tr.push_back(v);
            end
        end
    endtask

    initial begin
        period_t dir[5];
        bit      prev_cont;
        int      tmo_cnt, tmo_off, str_cnt;
        logic [6:0] at_tmo;

        dir[0] = '{1, 0, 1'b1};
        dir[1] = '{0, 0, 1'b0};
        dir[2] = '{4, 37, 1'b1};
        dir[3] = '{0, 1, 1'b1};
        dir[4] = '{0, 45, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_state", 32'(outs()), 32'(7'b1101000));
        rst_n = 1'b1;

        prev_cont = 1'b0;
        foreach (dir[d]) begin
            if (!prev_cont) add_idle((dir[d].idle_len < 1) ? 1 : dir[d].idle_len, 1'b1);
            add_period(dir[d].n, dir[d].cont);
            prev_cont = dir[d].cont;
        end
        for (int r = 0; r < 25; r++) begin
            int  n;
            bit  c;
            n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 45)) : 0;
            c = (r == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!prev_cont) add_idle(int'($urandom_range(1, 5)), 1'b1);
            add_period(n, c);
            prev_cont = c;
        end
        add_idle(3, 1'b0);

        for (int k = 0; k < tr.size(); k++) begin
            check($sformatf("trace[%0d]", k), 32'(outs()),
                  32'({tr[k].ph, tr[k].stb, tr[k].so, tr[k].bsy, tr[k].str, 1'b0}));
            enable = tr[k].en;
            scl_in = tr[k].si;
            @(negedge clk);
        end

        // Timeout: slave holds SCL low indefinitely from the phase 2 strobe.
        scl_in = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("tmo_start", 32'(outs()), 32'(7'b0010100));
        enable = 1'b0;
        repeat (2 * Q) @(negedge clk);
        check("tmo_phase2", 32'(outs()), 32'(7'b1011100));
        scl_in = 1'b0;
        tmo_cnt = 0;
        tmo_off = -1;
        str_cnt = 0;
        at_tmo  = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stretched) str_cnt++;
            if (tmo_err) begin
                tmo_cnt++;
                if (tmo_off < 0) begin
                    tmo_off = i;
                    at_tmo  = outs();
                end
            end
        end
        check("tmo_pulses", 32'(tmo_cnt), 32'd1);
        check("tmo_offset", 32'(tmo_off), 32'(TMO));
        check("tmo_stretch_cycles", 32'(str_cnt), 32'(TMO));
        check("tmo_idle_outs", 32'(at_tmo), 32'(7'b1101001));
        check("tmo_after", 32'(outs()), 32'(7'b1101000));
        scl_in = 1'b1;

        // Asynchronous reset in the middle of a stretch.
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2 * Q) @(negedge clk);
        scl_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pre_stretch", 32'(outs()), 32'(7'b1001110));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'(7'b1101000));
        enable = 1'b1;
        scl_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_phase0", 32'(outs()), 32'(7'b0010100));
        repeat (Q) @(negedge clk);
        check("restart_phase1", 32'(outs()), 32'(7'b0110100));
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
